tc_serializer: RTL
==================

TC_SERIALIZER -- requirements
Module: tc_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits; legal range 2..32.
REQ-002 t_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 r  input  1  reset, asynchronous, active-low; assertion clears all state immediately, regardless of t_clk.
REQ-004 load_valid  input  1  upstream offers a word on din.
REQ-005 din  input  WIDTH  parallel two's-complement operand to be serialized.
REQ-006 load_ready  output  1  block accepts din on this edge if load_valid=1.
REQ-007 i_out  output  1  serial bit to downstream complementer, LSB first.
REQ-008 bit_valid  output  1  i_out carries a valid operand bit this cycle.
REQ-009 last  output  1  current i_out is the MSB of the word.
REQ-010 frame_rst  output  1  active-high restart to downstream complementer; clears its "first 1 seen" state before each word.
REQ-011 frames_sent  output  8  count of completed words, modulo 256.

Function
REQ-012 FSM with exactly three states: IDLE, SYNC, SHIFT.
REQ-013 load_ready SHALL be 1 in IDLE, and in SHIFT when last=1; 0 otherwise, including SYNC.
REQ-014 Handshake: a transfer occurs on a rising edge where load_valid=1 and load_ready=1; din is captured into a WIDTH-bit shift register and the state goes to SYNC.
REQ-015 load_valid while load_ready=0 SHALL be ignored; the held word is not modified, and upstream must hold din until accepted.
REQ-016 SYNC lasts exactly one cycle: frame_rst=1, bit_valid=0, i_out=0, last=0; the next state is SHIFT with bit counter=0.
REQ-017 SHIFT: i_out=shreg[0], bit_valid=1, last=(counter==WIDTH-1), frame_rst=0; each edge shifts shreg right by one (0 fills MSB) and increments counter.
REQ-018 SHIFT lasts exactly WIDTH cycles; counter width is ceil(log2(WIDTH)) bits and never wraps inside a frame.
REQ-019 On the edge ending the last-bit cycle: if a transfer occurs (REQ-014) go to SYNC with the new word, else go to IDLE.
REQ-020 frames_sent increments on the edge ending the last-bit cycle; 255 wraps to 0.
REQ-021 Latency: accept on edge k; frame_rst high in cycle k..k+1; LSB valid in cycle k+1..k+2; MSB in cycle k+WIDTH..k+WIDTH+1.
REQ-022 Throughput: back-to-back words occupy WIDTH+1 cycles each, with no idle cycle between frames.
REQ-023 IDLE: bit_valid=0, last=0, frame_rst=0, i_out=0.

Reset
REQ-024 While r=0: state=IDLE, shreg=0, counter=0, frames_sent=0, i_out=0, bit_valid=0, last=0.
REQ-025 While r=0, frame_rst SHALL be forced to 1 combinationally, so the downstream stage is held cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no partial word resumes, and frames_sent does not count it.
REQ-027 After r deasserts, the first active edge finds load_ready=1, and a word can be accepted on it.

Verification
REQ-028 WIDTH=8, single word din=8'h06 -> frame_rst for 1 cycle, then i_out LSB-first 0,1,1,0,0,0,0,0 with bit_valid=1 for 8 cycles, last on the 8th, frames_sent=1; a downstream complementer yields 8'hFA.
REQ-029 Back-to-back 8'h01 then 8'h80, load_valid held high -> second SYNC directly follows the first MSB cycle; period 9 cycles; bit streams 10000000 then 00000001.
REQ-030 load_valid pulsed during SYNC and mid-SHIFT with a different din -> ignored; the in-flight word is unchanged, and load_ready=0 in those cycles.
REQ-031 r dropped low at the 4th bit of 8'hFF -> all outputs go to reset values immediately, frame_rst=1; after release, 8'h80 serializes correctly and frames_sent=1.
REQ-032 256 consecutive words -> frames_sent goes 255 to 0 on the 256th MSB edge.
REQ-033 din=0 and din=8'h80 (most-negative) -> streams all-zero and 0000000 then 1 respectively; bit_valid and last timing is identical to REQ-028.

Source files
------------

// File: rtl/tc_serializer.sv
// Parallel-to-serial front end for a bit-serial two's-complement stage.
// Each accepted word gets a one-cycle frame_rst, then WIDTH bits go out LSB first.
module tc_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             i_out,
  output logic             bit_valid,
  output logic             last,
  output logic             frame_rst,
  output logic [7:0]       frames_sent
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_inc;
  logic [7:0]       frames_reg;
  logic             i_out_reg;
  logic             bit_valid_reg;
  logic             last_reg;
  logic             sync_reg;
  logic             load_ready_reg;
  logic             accept;

  // Logical right shift with a zero entering at the MSB.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign shreg_shifted[gi] = 1'b0;
      end else begin : g_body
        assign shreg_shifted[gi] = shreg_reg[gi+1];
      end
    end
  endgenerate

  assign count_inc = count_reg + 1'b1;
  assign accept    = load_valid & load_ready_reg;

  // Outputs are carried in their own flops so every port is a clean register
  // output; next values are computed for the cycle being entered.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      count_reg      <= '0;
      frames_reg     <= 8'd0;
      i_out_reg      <= 1'b0;
      bit_valid_reg  <= 1'b0;
      last_reg       <= 1'b0;
      sync_reg       <= 1'b0;
      load_ready_reg <= 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg      <= SYNC;
            shreg_reg      <= din;
            count_reg      <= '0;
            sync_reg       <= 1'b1;
            load_ready_reg <= 1'b0;
          end
        end

        SYNC: begin
          state_reg      <= SHIFT;
          count_reg      <= '0;
          sync_reg       <= 1'b0;
          bit_valid_reg  <= 1'b1;
          i_out_reg      <= shreg_reg[0];
          last_reg       <= 1'b0;
          load_ready_reg <= 1'b0;
        end

        SHIFT: begin
          if (!last_reg) begin
            shreg_reg      <= shreg_shifted;
            count_reg      <= count_inc;
            i_out_reg      <= shreg_reg[1];
            last_reg       <= (count_inc == LAST_IDX);
            load_ready_reg <= (count_inc == LAST_IDX);
          end else begin
            // MSB cycle ends: count the frame and either chain or go idle.
            frames_reg    <= frames_reg + 8'd1;
            count_reg     <= '0;
            i_out_reg     <= 1'b0;
            bit_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
            if (accept) begin
              state_reg      <= SYNC;
              shreg_reg      <= din;
              sync_reg       <= 1'b1;
              load_ready_reg <= 1'b0;
            end else begin
              state_reg      <= IDLE;
              shreg_reg      <= shreg_shifted;
              sync_reg       <= 1'b0;
              load_ready_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg      <= IDLE;
          shreg_reg      <= '0;
          count_reg      <= '0;
          i_out_reg      <= 1'b0;
          bit_valid_reg  <= 1'b0;
          last_reg       <= 1'b0;
          sync_reg       <= 1'b0;
          load_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Downstream is held cleared for the whole time reset is low.
  assign frame_rst   = ~r | sync_reg;
  assign load_ready  = load_ready_reg;
  assign i_out       = i_out_reg;
  assign bit_valid   = bit_valid_reg;
  assign last        = last_reg;
  assign frames_sent = frames_reg;

endmodule
